// File: rtl/acc_adder.sv
// Accumulates unsigned operand beats into one framed sum with an overflow flag and a beat count.
// Latency: the result is presented in the cycle after the last beat of a frame is accepted.
// Backpressure: in_ready drops while a result is held; the result stays stable until out_ready.
module acc_adder #(
   parameter int WIDTH     = 10,
   parameter int ACC_WIDTH = 16,
   parameter bit SATURATE  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_first,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_sum,
   output logic                 out_ovf,
   output logic [7:0]           out_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [ACC_WIDTH-1:0]   acc;
   logic [ACC_WIDTH-1:0]   acc_nxt;
   logic                   ovf;
   logic                   ovf_nxt;
   logic [7:0]             count;
   logic [7:0]             count_nxt;

   logic                   accept;
   logic                   restart;
   logic                   carry;
   logic [ACC_WIDTH-1:0]   data_ext;
   logic [ACC_WIDTH:0]     sum_ext;

   // Handshake and output view: outputs are the registered accumulator, so they
   // cannot move while the result is held.
   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign out_sum   = acc;
   assign out_ovf   = ovf;
   assign out_count = count;

   assign accept   = in_valid && in_ready;
   // A beat arriving in IDLE always opens a new frame, flagged or not.
   assign restart  = accept && (in_first || (state == IDLE));
   assign data_ext = ACC_WIDTH'(in_data);
   assign sum_ext  = {1'b0, acc} + {1'b0, data_ext};
   assign carry    = sum_ext[ACC_WIDTH];

   // Next-state logic for the frame FSM.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = in_last ? HOLD : ACCUM;
         end
         ACCUM: begin
            if (accept && in_last) state_nxt = HOLD;
         end
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulator, sticky overflow and saturating beat count for the next cycle.
   always_comb begin
      acc_nxt   = acc;
      ovf_nxt   = ovf;
      count_nxt = count;
      if (restart) begin
         acc_nxt   = data_ext;
         ovf_nxt   = 1'b0;
         count_nxt = 8'd1;
      end else if (accept) begin
         ovf_nxt   = ovf | carry;
         // Once clamped, the sum stays all-ones for the rest of the frame.
         if (SATURATE && (ovf || carry)) begin
            acc_nxt = '1;
         end else begin
            acc_nxt = sum_ext[ACC_WIDTH-1:0];
         end
         count_nxt = (count == 8'd255) ? count : (count + 8'd1);
      end
   end

   // State and datapath registers; reset wins over any concurrent beat or handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         ovf   <= 1'b0;
         count <= 8'd0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         ovf   <= ovf_nxt;
         count <= count_nxt;
      end
   end

endmodule
